rate_encoder_aer: RTL and testbench

Parametrised Poisson-rate spike encoder. It scans an external pixel memory over `T_STEPS` timesteps per frame. Each pixel value is compared against an LFSR draw to decide whether it emits a spike. Spikes are buffered in a small FIFO and sent as `{timestep, pixel}` events on a 4-phase AER link to the core. It sits between the image buffer and the neuron core input arbiter, and adds a multi-timestep frame loop, an output FIFO with back-pressure and abort.

---
 rtl/rate_encoder_aer.sv | 197 +++++++++++++++++++
 tb/tb_rate_encoder_aer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rate_encoder_aer.sv
// Poisson-rate spike encoder: scans a pixel memory for T_STEPS timesteps and
// emits {timestep, pixel} events over a 4-phase AER link through a small FIFO.
module rate_encoder_aer #(
  parameter int unsigned       N_PIX      = 784,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       RAND_W     = 12,
  parameter logic [RAND_W-1:0] LFSR_TAPS  = 12'hA96,
  parameter logic [RAND_W-1:0] LFSR_SEED  = 12'hAA7,
  parameter int unsigned       TS_W       = 4,
  parameter int unsigned       T_STEPS    = 8,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   start,
  input  logic                   abort,
  output logic [ADDR_W-1:0]      pix_addr,
  input  logic [PIX_W-1:0]       pix_data,
  output logic [TS_W+ADDR_W-1:0] AER_ADDR,
  output logic                   AER_REQ,
  input  logic                   AER_ACK,
  output logic                   busy,
  output logic [TS_W-1:0]        timestep,
  output logic                   frame_done
);

  localparam int unsigned       EV_W     = TS_W + ADDR_W;
  localparam int unsigned       PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned       CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIX - 1);
  localparam logic [TS_W-1:0]   LAST_TS  = TS_W'(T_STEPS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

  state_t state, state_nxt;

  logic              start_scan, abort_scan, issue, done_nxt;
  logic              scan_done, aborted;
  logic              cmp_valid, cmp_last;
  logic [ADDR_W-1:0] cmp_addr;
  logic [TS_W-1:0]   cmp_ts;
  logic [RAND_W-1:0] lfsr, lfsr_next, thr;
  logic              spike, push, pop, load;
  logic              ack_m, ack_s;

  logic [EV_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Issue is throttled so queued events plus the in-flight compare never exceed the FIFO.
  always_comb begin
    state_nxt  = state;
    start_scan = 1'b0;
    abort_scan = 1'b0;
    issue      = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_scan = 1'b1;
          state_nxt  = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort) begin
          abort_scan = 1'b1;
          state_nxt  = S_DRAIN;
        end else begin
          issue = !scan_done &&
                  ((32'(fifo_cnt) + 32'(cmp_valid)) < FIFO_DEPTH);
          if (cmp_valid && cmp_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_cnt == '0 && !AER_REQ && !ack_s) begin
          state_nxt = S_IDLE;
          done_nxt  = !aborted;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    lfsr_next = {lfsr[RAND_W-2:0], lfsr[RAND_W-1]} ^ ({RAND_W{lfsr[RAND_W-1]}} & LFSR_TAPS);
    thr       = RAND_W'(pix_data) << (RAND_W - PIX_W);
    spike     = (pix_data == '1) || ((pix_data != '0) && (lfsr < thr));
    push      = cmp_valid && spike && !abort_scan;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pix_addr   <= '0;
      timestep   <= '0;
      scan_done  <= 1'b0;
      aborted    <= 1'b0;
      cmp_valid  <= 1'b0;
      cmp_last   <= 1'b0;
      cmp_addr   <= '0;
      cmp_ts     <= '0;
      lfsr       <= LFSR_SEED;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      if (start_scan) begin
        lfsr      <= LFSR_SEED;
        pix_addr  <= '0;
        timestep  <= '0;
        scan_done <= 1'b0;
        aborted   <= 1'b0;
        cmp_valid <= 1'b0;
      end else if (abort_scan) begin
        cmp_valid <= 1'b0;
        scan_done <= 1'b1;
        aborted   <= 1'b1;
      end else begin
        if (cmp_valid) lfsr <= lfsr_next;
        cmp_valid <= issue;
        if (issue) begin
          cmp_addr <= pix_addr;
          cmp_ts   <= timestep;
          cmp_last <= (pix_addr == LAST_PIX) && (timestep == LAST_TS);
          if (pix_addr == LAST_PIX) begin
            pix_addr <= '0;
            if (timestep == LAST_TS) scan_done <= 1'b1;
            else                     timestep  <= timestep + TS_W'(1);
          end else begin
            pix_addr <= pix_addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ack_m <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      ack_m <= AER_ACK;
      ack_s <= ack_m;
    end
  end

  assign pop  = AER_REQ && ack_s;
  assign load = (fifo_cnt != '0) && !AER_REQ && !ack_s && !abort_scan;

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {cmp_ts, cmp_addr};
  end

  // On abort only the entry currently on the link (if any) survives, at rd_ptr.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (abort_scan) begin
      rd_ptr   <= pop ? ptr_inc(rd_ptr) : rd_ptr;
      wr_ptr   <= AER_REQ ? ptr_inc(rd_ptr) : rd_ptr;
      fifo_cnt <= (AER_REQ && !pop) ? CNT_W'(1) : '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      AER_REQ  <= 1'b0;
      AER_ADDR <= '0;
    end else if (pop) begin
      AER_REQ <= 1'b0;
    end else if (load) begin
      AER_REQ  <= 1'b1;
      AER_ADDR <= fifo_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_rate_encoder_aer.sv
// Bench for rate_encoder_aer: event sequences checked against a frame-level
// model of the Poisson encoder (16 pixels, 2 timesteps).
module tb_rate_encoder_aer;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       AER_ACK = 1'b0;
  logic [3:0] pix_addr;
  logic [7:0] pix_data = '0;
  logic [7:0] AER_ADDR;
  logic       AER_REQ;
  logic       busy;
  logic [3:0] timestep;
  logic       frame_done;

  rate_encoder_aer #(
    .N_PIX(16), .ADDR_W(4), .PIX_W(8), .RAND_W(12),
    .LFSR_TAPS(12'hA96), .LFSR_SEED(12'hAA7),
    .TS_W(4), .T_STEPS(2), .FIFO_DEPTH(4)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
    .pix_addr(pix_addr), .pix_data(pix_data),
    .AER_ADDR(AER_ADDR), .AER_REQ(AER_REQ), .AER_ACK(AER_ACK),
    .busy(busy), .timestep(timestep), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  logic [7:0] img [16];
  always @(posedge CLK) pix_data <= img[pix_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] lfsr_step(input logic [11:0] r);
    return {r[10:0], r[11]} ^ (r[11] ? 12'hA96 : 12'h000);
  endfunction

  logic [7:0] exp_q[$];

  // Whole-frame model: one random draw per pixel, row-major over timesteps.
  function automatic void build_exp();
    logic [11:0] r;
    logic [7:0]  v;
    bit          sp;
    exp_q.delete();
    r = 12'hAA7;
    for (int ts = 0; ts < 2; ts++) begin
      for (int p = 0; p < 16; p++) begin
        v = img[p];
        if (v == 8'hFF)   sp = 1'b1;
        else if (v == 0)  sp = 1'b0;
        else              sp = (int'(r) < int'(v) * 16);
        if (sp) exp_q.push_back({4'(ts), 4'(p)});
        r = lfsr_step(r);
      end
    end
  endfunction

  int         rx_cnt = 0;
  int         done_cnt = 0;
  logic       req_d = 1'b0;
  logic [7:0] cur_exp = '0;

  always @(negedge CLK) begin
    if (frame_done) done_cnt++;
    if (AER_REQ && !req_d) begin
      rx_cnt++;
      chk("req_rise_ack_low", AER_ACK, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got 0x%0h, expected none", AER_ADDR);
      end else begin
        cur_exp = exp_q.pop_front();
        chk("event_addr", AER_ADDR, cur_exp);
      end
    end else if (AER_REQ) begin
      chk("event_hold", AER_ADDR, cur_exp);
    end
    req_d = AER_REQ;
  end

  logic ack_hold = 1'b1;
  int   ack_wait = 0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      AER_ACK  = 1'b0;
      ack_wait = 0;
    end else if (AER_REQ && !AER_ACK && !ack_hold) begin
      if (ack_wait >= 1) begin
        AER_ACK  = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end else if (!AER_REQ && AER_ACK) begin
      AER_ACK = 1'b0;
    end
  end

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge CLK);
      n++;
    end
    chk(name, busy, 0);
    repeat (3) @(negedge CLK);
  endtask

  task automatic run_frame(input string tag);
    int rx0, d0, ne;
    build_exp();
    ne  = exp_q.size();
    rx0 = rx_cnt;
    d0  = done_cnt;
    pulse_start();
    wait_idle(3000, {tag, "_idle"});
    chk({tag, "_events"}, rx_cnt - rx0, ne);
    chk({tag, "_missing"}, exp_q.size(), 0);
    chk({tag, "_done_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int n, rx0, d0;
    for (int p = 0; p < 16; p++) img[p] = 8'h00;

    repeat (3) @(negedge CLK);
    chk("rst_req", AER_REQ, 0);
    chk("rst_aer_addr", AER_ADDR, 0);
    chk("rst_pix_addr", pix_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timestep", timestep, 0);
    chk("rst_frame_done", frame_done, 0);
    RST_N = 1'b1;
    ack_hold = 1'b0;

    chk("model_lfsr1", lfsr_step(12'hAA7), 12'hFD9);
    chk("model_lfsr2", lfsr_step(lfsr_step(12'hAA7)), 12'h525);
    chk("model_lfsr3", lfsr_step(lfsr_step(lfsr_step(12'hAA7))), 12'hA4A);

    // All-zero image: no events, single frame_done about 34 cycles after start
    exp_q.delete();
    rx0 = rx_cnt; d0 = done_cnt;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("zero_busy", busy, 1);
    n = 1;
    while (!frame_done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("zero_latency_window", (n >= 32 && n <= 38), 1);
    wait_idle(100, "zero_idle");
    chk("zero_events", rx_cnt - rx0, 0);
    chk("zero_done_pulses", done_cnt - d0, 1);

    // Saturated image: every pixel spikes, in scan order
    for (int p = 0; p < 16; p++) img[p] = 8'hFF;
    build_exp();
    chk("model_ff_count", exp_q.size(), 32);
    chk("model_ff_last", exp_q[31], 8'h1F);
    run_frame("ff");

    // Back-pressure: ACK withheld, scan freezes once FIFO is full
    ack_hold = 1'b1;
    build_exp();
    rx0 = rx_cnt; d0 = done_cnt;
    pulse_start();
    repeat (200) @(negedge CLK);
    chk("stall_pix_addr", pix_addr, 4);
    chk("stall_req", AER_REQ, 1);
    chk("stall_aer_addr", AER_ADDR, 8'h00);
    chk("stall_busy", busy, 1);
    ack_hold = 1'b0;
    wait_idle(3000, "stall_idle");
    chk("stall_events", rx_cnt - rx0, 32);
    chk("stall_missing", exp_q.size(), 0);
    chk("stall_done_pulses", done_cnt - d0, 1);

    // Mid-range pixels: first draw below 0x800 is the third (0x525) -> pixel 2
    for (int p = 0; p < 16; p++) img[p] = (p < 4) ? 8'h80 : 8'h00;
    build_exp();
    chk("model_80_first", exp_q[0], 8'h02);
    run_frame("half");

    // Random image, two back-to-back frames against the same expectation
    for (int p = 0; p < 16; p++) img[p] = 8'($urandom_range(0, 255));
    img[3] = 8'h00;
    img[7] = 8'hFF;
    run_frame("rand_a");
    run_frame("rand_b");

    // Abort with REQ high: only the event on the link completes
    for (int p = 0; p < 16; p++) img[p] = 8'hFF;
    ack_hold = 1'b1;
    exp_q.delete();
    exp_q.push_back(8'h00);
    rx0 = rx_cnt; d0 = done_cnt;
    pulse_start();
    repeat (20) @(negedge CLK);
    chk("abort_req_before", AER_REQ, 1);
    abort = 1'b1;
    @(negedge CLK); abort = 1'b0;
    ack_hold = 1'b0;
    wait_idle(500, "abort_idle");
    chk("abort_events", rx_cnt - rx0, 1);
    chk("abort_missing", exp_q.size(), 0);
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame("after_abort");

    // Asynchronous reset during a handshake
    ack_hold = 1'b1;
    build_exp();
    pulse_start();
    n = 0;
    while (!AER_REQ && n < 50) begin
      @(negedge CLK);
      n++;
    end
    chk("rst_mid_req_seen", AER_REQ, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_req", AER_REQ, 0);
    chk("rst_mid_aer_addr", AER_ADDR, 0);
    chk("rst_mid_pix_addr", pix_addr, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_timestep", timestep, 0);
    chk("rst_mid_frame_done", frame_done, 0);
    exp_q.delete();
    @(negedge CLK); RST_N = 1'b1;
    ack_hold = 1'b0;
    rx0 = rx_cnt;
    repeat (30) @(negedge CLK);
    chk("rst_quiet_events", rx_cnt - rx0, 0);
    chk("rst_quiet_req", AER_REQ, 0);
    chk("rst_quiet_busy", busy, 0);
    run_frame("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
